// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: registered EX operand forwarding selects, load-use
// stall, branch flush, and a whole-pipeline freeze during multi-cycle data-memory accesses.
module hazard_ctrl #(
  parameter int DM_LATENCY = 4,
  parameter int REG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_we,
  input  logic             ex_memtoreg,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_we,
  input  logic             mem_access,
  input  logic             br_taken,
  output logic [1:0]       fwd_mux1,
  output logic [1:0]       fwd_mux2,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_stall,
  output logic             mem_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } state_t;

  localparam logic [1:0] FWD_EX  = 2'b10;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [3:0] WAIT_LOAD = 4'(DM_LATENCY - 1);

  state_t     r_state, w_state_next;
  logic [3:0] r_cnt, w_cnt_next;
  logic [1:0] r_fwd1, r_fwd2;
  logic [1:0] w_fwd1_next, w_fwd2_next;
  logic       w_in_wait;
  logic       w_load_use;

  // EX/EX wins over MEM/EX; a load in EX cannot forward yet, and r0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src, input logic used);
    if (used && ex_we && (ex_rd != '0) && (src == ex_rd) && !ex_memtoreg)
      return FWD_EX;
    else if (used && mem_we && (mem_rd != '0) && (src == mem_rd))
      return FWD_MEM;
    else
      return FWD_RF;
  endfunction

  assign w_in_wait   = (r_state == MEM_WAIT);
  assign w_fwd1_next = fwd_sel(id_rs, id_rs_used);
  assign w_fwd2_next = fwd_sel(id_rt, id_rt_used);
  assign w_load_use  = ex_we && ex_memtoreg && (ex_rd != '0) &&
                       ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (mem_access && (DM_LATENCY > 1)) begin
          w_state_next = MEM_WAIT;
          w_cnt_next   = WAIT_LOAD;
        end
      end
      MEM_WAIT: begin
        if (r_cnt == 4'd1) w_state_next = MEM_DONE;
        w_cnt_next = r_cnt - 4'd1;
      end
      MEM_DONE: w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_stall = 1'b0;
    mem_busy    = 1'b0;
    if (w_in_wait) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_stall = 1'b1;
      mem_busy    = 1'b1;
    end else if (br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_fwd1  <= FWD_RF;
      r_fwd2  <= FWD_RF;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (!w_in_wait) begin
        r_fwd1 <= idex_flush ? FWD_RF : w_fwd1_next;
        r_fwd2 <= idex_flush ? FWD_RF : w_fwd2_next;
      end
    end
  end

  assign fwd_mux1 = r_fwd1;
  assign fwd_mux2 = r_fwd2;

endmodule
